bip_control_unit: RTL
=====================

// Module: bip_control_unit
// PURPOSE
// - Multi-cycle fetch/decode/execute control for the BIP-2 CPU. Holds PC, IR, ACC and STATUS (Z,N).
// - Directly upstream of the combinational ALU: drives its operands and add/sub select.
// - Consumes the ALU result and flags in the same cycle, then writes them to ACC/STATUS.
// PARAMETERS
// - ADDR_W   11  PC / data address width
// - DATA_W   11  ACC, ALU operand and data-memory word width
// - INSTR_W  16  instruction width = OPC_W + operand field (INSTR_W-OPC_W must equal ADDR_W)
// - OPC_W    5   opcode field, instr[15:11]
// PORTS
// - clk           in   1        rising-edge clock
// - rst_n         in   1        asynchronous, active-low reset
// - instr_addr    out  ADDR_W   instruction memory address (=PC)
// - instr_rd      out  1        instruction read strobe
// - instr_data    in   INSTR_W  instruction word, valid 1 cycle after instr_rd
// - data_addr     out  ADDR_W   data memory address (=IR operand)
// - data_rd       out  1        data read strobe
// - data_wr       out  1        data write strobe
// - data_wdata    out  DATA_W   write data (=ACC)
// - data_rdata    in   DATA_W   read data, valid 1 cycle after data_rd
// - alu_operand1  out  DATA_W   always ACC
// - alu_operand2  out  DATA_W   data_rdata (ADD/SUB) or IR operand (ADDI/SUBI/other)
// - alu_operation out  1        0=add, 1=sub (SUB/SUBI only, else 0)
// - alu_result    in   DATA_W   ALU result, same cycle
// - alu_z, alu_n  in   1        ALU zero / negative flags, same cycle
// - halted        out  1        1 while in S_HALT
// BEHAVIOUR
// - Reset (async assert, sync release): PC=0, IR=0, ACC=0, Z=0, N=0, state=S_FETCH.
//   All strobes and halted are 0; reset mid-instruction aborts it with no memory write.
// - S_FETCH: instr_rd=1, instr_addr=PC -> S_DECODE.
// - S_DECODE: IR<=instr_data. Opcodes LD/ADD/SUB -> S_MEMRD; HLT -> S_HALT; else -> S_EXEC.
// - S_MEMRD: data_rd=1, data_addr=IR[10:0] -> S_EXEC.
// - S_EXEC (one cycle, then S_FETCH):
//   - STO: data_wr=1, data_addr=operand, data_wdata=ACC.
//   - LD: ACC<=data_rdata. LDI: ACC<=operand. Neither touches Z/N.
//   - ADD/SUB/ADDI/SUBI: ACC<=alu_result; Z<=alu_z; N<=alu_n.
//   - Branch taken: PC<=operand. Otherwise (incl. not-taken branch): PC<=PC+1.
// - S_HALT: absorbing; halted=1, no strobes, PC/ACC/STATUS frozen until rst_n low.
// - Opcodes: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB,
//   00111 SUBI, 01000 BEQ, 01001 BNE, 01010 BGT, 01011 BGE, 01100 BLT, 01101 BLE, 01110 JMP.
//   Remaining opcodes are NOP (PC+1, no state change).
// - Branch conditions use STATUS registers, not live ALU flags:
//   BEQ Z; BNE !Z; BGT !Z&!N; BGE !N; BLT N; BLE N|Z; JMP always.
// - Latency: 3 cycles/instr; LD/ADD/SUB take 4.
// - Strobes are mutually exclusive; at most one is high per cycle.
// - Arithmetic is modulo 2^DATA_W, no overflow flag.
// - PC wraps: 2047+1 -> 0.
// - Outside S_EXEC, ACC/Z/N hold regardless of alu_* inputs.
// CONFIGURATION
// - BIP_EXT_BRANCH_EN defined: BGT/BGE/BLT/BLE decode as above.
// - BIP_EXT_BRANCH_EN undefined: those four opcodes are NOP; BEQ/BNE/JMP are unaffected.
// STRUCTURE
// - bip_pkg: opcode localparams, state encoding (S_FETCH..S_HALT), widths.
// - Sub-module bip_branch_eval: combinational (opcode, Z, N) -> taken; contains the _EN ifdef.
// TESTING
// - Reset: hold rst_n=0 -> instr_addr=0, all strobes 0, halted=0; release -> instr_rd=1 at cycle 0.
// - LDI 5; ADDI 3; STO 0x010 -> data_wr=1, data_addr=0x010, data_wdata=8; Z=0, N=0.
// - LDI 2; SUBI 3 -> ACC=0x7FF, N=1; then BLT 0x020 -> next instr_addr=0x020 (with _EN).
//   Without _EN, the same BLT is NOP -> next instr_addr = PC+1.
// - LDI 4; SUBI 4 -> Z=1; then BEQ 0x100 -> taken. LDI 1 (Z stays 1); BNE 0x100 -> not taken.
// - LD 0x005 with mem[5]=9 -> data_rd 1 cycle, ACC=9, 4-cycle instruction, flags unchanged.
// - HLT -> halted=1, no strobes for 20 cycles; mid-ADD rst_n pulse -> PC=0, ACC=0.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP-2 control unit: widths, opcodes and FSM state encoding.
// Build option: BIP_EXT_BRANCH_EN (see bip_branch_eval) enables BGT/BGE/BLT/BLE.
package bip_pkg;

    localparam int BIP_ADDR_W  = 11;
    localparam int BIP_DATA_W  = 11;
    localparam int BIP_INSTR_W = 16;
    localparam int BIP_OPC_W   = 5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEMRD  = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BGT  = 5'b01010;
    localparam logic [4:0] OP_BGE  = 5'b01011;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BLE  = 5'b01101;
    localparam logic [4:0] OP_JMP  = 5'b01110;

    // Opcodes whose operand is a data-memory address that must be read first.
    function automatic logic needs_mem_read(input logic [4:0] opc);
        return (opc == OP_LD) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/bip_branch_eval.sv
// Combinational branch decision from the opcode and the registered STATUS flags.
// Build option: BIP_EXT_BRANCH_EN adds BGT/BGE/BLT/BLE; otherwise those opcodes are never taken.
module bip_branch_eval
    import bip_pkg::*;
(
    input  logic [4:0] i_opcode,
    input  logic       i_z,
    input  logic       i_n,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_opcode)
            OP_BEQ:  o_taken = i_z;
            OP_BNE:  o_taken = ~i_z;
            OP_JMP:  o_taken = 1'b1;
`ifdef BIP_EXT_BRANCH_EN
            OP_BGT:  o_taken = ~i_z & ~i_n;
            OP_BGE:  o_taken = ~i_n;
            OP_BLT:  o_taken = i_n;
            OP_BLE:  o_taken = i_n | i_z;
`else
            OP_BGT, OP_BGE, OP_BLT, OP_BLE: o_taken = 1'b0;
`endif
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP-2 multi-cycle fetch/decode/execute control: holds PC, IR, ACC and STATUS (Z,N).
// Build option: BIP_EXT_BRANCH_EN enables the signed-compare branches in bip_branch_eval.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int ADDR_W  = BIP_ADDR_W,
    parameter int DATA_W  = BIP_DATA_W,
    parameter int INSTR_W = BIP_INSTR_W,
    parameter int OPC_W   = BIP_OPC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               instr_rd,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  data_addr,
    output logic               data_rd,
    output logic               data_wr,
    output logic [DATA_W-1:0]  data_wdata,
    input  logic [DATA_W-1:0]  data_rdata,
    output logic [DATA_W-1:0]  alu_operand1,
    output logic [DATA_W-1:0]  alu_operand2,
    output logic               alu_operation,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_z,
    input  logic               alu_n,
    output logic               halted,
    output logic [2:0]         o_dbg_state
);

    // Handshake: instr_rd / data_rd are one-cycle requests whose data is valid
    // the following cycle; data_wr is a one-cycle write with address and data
    // valid in the same cycle. At most one strobe is high in any cycle.

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_acc;
    logic                r_z;
    logic                r_n;

    logic [OPC_W-1:0]    w_opcode;
    logic [OPC_W-1:0]    w_in_opcode;
    logic [ADDR_W-1:0]   w_operand;
    logic [DATA_W-1:0]   w_operand_data;
    logic                w_taken;
    logic                w_ir_we;
    logic                w_acc_we;
    logic [DATA_W-1:0]   w_acc_d;
    logic                w_flags_we;
    logic                w_pc_we;
    logic [ADDR_W-1:0]   w_pc_d;

    assign w_opcode       = r_ir[INSTR_W-1 -: OPC_W];
    assign w_in_opcode    = instr_data[INSTR_W-1 -: OPC_W];
    assign w_operand      = r_ir[INSTR_W-OPC_W-1:0];
    assign w_operand_data = DATA_W'(w_operand);

    assign instr_addr    = r_pc;
    assign data_addr     = w_operand;
    assign data_wdata    = r_acc;
    assign alu_operand1  = r_acc;
    assign alu_operand2  = ((w_opcode == OP_ADD) || (w_opcode == OP_SUB)) ? data_rdata
                                                                           : w_operand_data;
    assign alu_operation = (w_opcode == OP_SUB) || (w_opcode == OP_SUBI);
    assign halted        = (r_state == S_HALT);
    assign o_dbg_state   = r_state;

    bip_branch_eval u_branch_eval (
        .i_opcode (w_opcode),
        .i_z      (r_z),
        .i_n      (r_n),
        .o_taken  (w_taken)
    );

    always_comb begin
        w_next_state = r_state;
        instr_rd     = 1'b0;
        data_rd      = 1'b0;
        data_wr      = 1'b0;
        w_ir_we      = 1'b0;
        w_acc_we     = 1'b0;
        w_acc_d      = r_acc;
        w_flags_we   = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_d       = r_pc + ADDR_W'(1);

        case (r_state)
            S_FETCH: begin
                // Reset parks the FSM in S_FETCH; keep the strobe quiet until release.
                instr_rd     = rst_n;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_ir_we = 1'b1;
                if (needs_mem_read(w_in_opcode)) begin
                    w_next_state = S_MEMRD;
                end else if (w_in_opcode == OP_HLT) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_MEMRD: begin
                data_rd      = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                w_next_state = S_FETCH;
                w_pc_we      = 1'b1;
                if (w_taken) begin
                    w_pc_d = w_operand;
                end
                case (w_opcode)
                    OP_STO: data_wr = 1'b1;
                    OP_LD: begin
                        w_acc_we = 1'b1;
                        w_acc_d  = data_rdata;
                    end
                    OP_LDI: begin
                        w_acc_we = 1'b1;
                        w_acc_d  = w_operand_data;
                    end
                    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                        w_acc_we   = 1'b1;
                        w_acc_d    = alu_result;
                        w_flags_we = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_acc <= '0;
            r_z   <= 1'b0;
            r_n   <= 1'b0;
        end else begin
            if (w_ir_we) begin
                r_ir <= instr_data;
            end
            if (w_pc_we) begin
                r_pc <= w_pc_d;
            end
            if (w_acc_we) begin
                r_acc <= w_acc_d;
            end
            if (w_flags_we) begin
                r_z <= alu_z;
                r_n <= alu_n;
            end
        end
    end

endmodule
